// File: rtl/nec_prefetch_ctrl.sv
// Instruction prefetch controller: fetches code bytes at ps*16 + fetch_pc into
// an 8-byte circular queue indexed by address[2:0], one bus request at a time.
// A flush restarts fetching at new_pc. A request that is already on the bus is
// still completed, but its data is thrown away.
module nec_prefetch_ctrl (
  input  logic            clk,
  input  logic            reset,
  input  logic            ce,
  input  logic [15:0]     ps,
  input  logic            flush,
  input  logic [15:0]     new_pc,
  input  logic [15:0]     dec_pc,
  input  logic            exec_hold,
  output logic            bus_req,
  output logic [19:0]     bus_addr,
  output logic            bus_byte,
  input  logic            bus_ack,
  input  logic [15:0]     bus_data,
  output logic [7:0][7:0] ipq,
  output logic [3:0]      ipq_len
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [15:0] fetch_pc;
  logic [15:0] pc_diff;
  logic        has_room;
  logic        issue;
  logic        accept;
  logic [2:0]  slot0;
  logic [2:0]  slot1;

  // The queue occupancy is the distance from the decoder to the fetch pointer.
  // The decoder never trails by more than 8, so the low nibble carries the whole
  // count. At least 2 bytes must be free, which means no more than 6 are held.
  assign pc_diff  = fetch_pc - dec_pc;
  assign ipq_len  = pc_diff[3:0];
  assign has_room = (pc_diff <= 16'd6);

  // The bus request is high for the whole time a request is outstanding,
  // including a request whose data will be discarded.
  assign bus_req  = (state != IDLE);

  // Queue slots for the two bytes of a word fetch. The index wraps in 3 bits.
  assign slot0    = fetch_pc[2:0];
  assign slot1    = fetch_pc[2:0] + 3'd1;

  // State register. It advances only on enabled cycles. Reset overrides ce.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only. Every register
    // then samples values from before the edge, so the order of the
    // always_ff blocks cannot change the result.
    if (reset) begin
      state <= IDLE;
    end else if (ce) begin
      state <= state_next;
    end
  end

  // Next-state logic and the one-cycle issue and accept strobes.
  always_comb begin
    // NOTE: every output of this block gets a default first. A path that does
    // not assign a signal then holds the default, and no latch is inferred.
    state_next = state;
    issue      = 1'b0;
    accept     = 1'b0;
    unique case (state)
      IDLE: begin
        if (!flush && !exec_hold && has_room) begin
          state_next = REQ;
          issue      = 1'b1;
        end
      end
      REQ: begin
        if (bus_ack) begin
          // If flush arrives with the ack, the data is already stale.
          state_next = IDLE;
          accept     = !flush;
        end else if (flush) begin
          state_next = DISCARD;
        end
      end
      DISCARD: begin
        if (bus_ack) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Fetch pointer and latched request. A flush always reloads the pointer.
  // The address and byte mode are frozen while a request is outstanding.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= 16'h0000;
      bus_addr <= 20'h00000;
      bus_byte <= 1'b0;
    end else if (ce) begin
      if (flush) begin
        fetch_pc <= new_pc;
      end else if (accept) begin
        fetch_pc <= fetch_pc + (bus_byte ? 16'd1 : 16'd2);
      end
      if (issue) begin
        bus_addr <= {ps, 4'h0} + {4'h0, fetch_pc};
        bus_byte <= fetch_pc[0];
      end
    end
  end

  // Queue storage. Slots are written only when a fetch is accepted.
  always_ff @(posedge clk) begin
    // NOTE: the queue is small and must come out of reset as all zeros, so it
    // is built from resettable flops and not from a RAM macro.
    if (reset) begin
      ipq <= '0;
    end else if (ce && accept) begin
      if (bus_byte) begin
        ipq[slot0] <= bus_data[15:8];
      end else begin
        ipq[slot0] <= bus_data[7:0];
        ipq[slot1] <= bus_data[15:8];
      end
    end
  end

endmodule

// File: tb/tb_nec_prefetch_ctrl.sv
// Testbench for nec_prefetch_ctrl. A transaction-level model predicts every
// output after each clock edge. The model tracks an outstanding-request flag,
// a discard flag, the fetch offset and an 8-byte array. Directed scenarios run
// first, then randomized traffic follows.
module tb_nec_prefetch_ctrl;

  logic            clk = 1'b0;
  logic            reset;
  logic            ce;
  logic [15:0]     ps;
  logic            flush;
  logic [15:0]     new_pc;
  logic [15:0]     dec_pc;
  logic            exec_hold;
  logic            bus_req;
  logic [19:0]     bus_addr;
  logic            bus_byte;
  logic            bus_ack;
  logic [15:0]     bus_data;
  logic [7:0][7:0] ipq;
  logic [3:0]      ipq_len;

  nec_prefetch_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .ce        (ce),
    .ps        (ps),
    .flush     (flush),
    .new_pc    (new_pc),
    .dec_pc    (dec_pc),
    .exec_hold (exec_hold),
    .bus_req   (bus_req),
    .bus_addr  (bus_addr),
    .bus_byte  (bus_byte),
    .bus_ack   (bus_ack),
    .bus_data  (bus_data),
    .ipq       (ipq),
    .ipq_len   (ipq_len)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  bit          m_pend;
  bit          m_disc;
  bit          m_byte;
  logic [19:0] m_addr;
  logic [15:0] m_fpc;
  logic [7:0]  m_q [8];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [15:0] m_len();
    return m_fpc - dec_pc;
  endfunction

  function automatic logic [63:0] m_vec();
    logic [63:0] v;
    for (int i = 0; i < 8; i++) v[i*8 +: 8] = m_q[i];
    return v;
  endfunction

  // Apply the current inputs to the model, as one clock edge does.
  task automatic model_edge();
    int len;
    len = int'(m_len());
    if (reset) begin
      m_pend = 0; m_disc = 0; m_byte = 0; m_addr = '0; m_fpc = '0;
      for (int i = 0; i < 8; i++) m_q[i] = 8'h00;
    end else if (ce) begin
      if (!m_pend) begin
        if (flush) m_fpc = new_pc;
        else if (!exec_hold && (8 - len) >= 2) begin
          m_pend = 1;
          m_disc = 0;
          m_addr = 20'((int'(ps) * 16 + int'(m_fpc)) % 1048576);
          m_byte = m_fpc[0];
        end
      end else begin
        if (bus_ack && !m_disc && !flush) begin
          if (m_byte) begin
            m_q[m_fpc % 8] = bus_data[15:8];
            m_fpc = m_fpc + 16'd1;
          end else begin
            m_q[m_fpc % 8] = bus_data[7:0];
            m_q[(m_fpc + 16'd1) % 8] = bus_data[15:8];
            m_fpc = m_fpc + 16'd2;
          end
        end
        if (flush) m_fpc = new_pc;
        if (bus_ack) begin
          m_pend = 0;
          m_disc = 0;
        end else if (flush) begin
          m_disc = 1;
        end
      end
    end
  endtask

  // One clock cycle: update the model, clock the DUT, compare the outputs.
  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check("bus_req", 64'(bus_req), 64'(m_pend));
    check("bus_addr", 64'(bus_addr), 64'(m_addr));
    if (m_pend) check("bus_byte", 64'(bus_byte), 64'(m_byte));
    check("ipq_len", 64'(ipq_len), 64'(m_len()));
    check("ipq", ipq, m_vec());
  endtask

  task automatic idle_inputs();
    reset = 0; ce = 1; flush = 0; exec_hold = 0; bus_ack = 0; bus_data = 16'h0000;
  endtask

  initial begin
    int acks;
    logic [15:0] len16;
    ps = 16'h0000; new_pc = 16'h0000; dec_pc = 16'h0000;
    idle_inputs();
    m_pend = 0; m_disc = 0; m_byte = 0; m_addr = '0; m_fpc = '0;
    for (int i = 0; i < 8; i++) m_q[i] = 8'h00;

    // Reset with ce low
    reset = 1; ce = 0; bus_ack = 1;
    step();
    check("rst_req", 64'(bus_req), 64'd0);
    check("rst_addr", 64'(bus_addr), 64'd0);
    check("rst_ipq", ipq, 64'd0);
    idle_inputs();

    // Flush to 0xFFF0 with ps=0xF000, then ack every request with 0x3412
    ps = 16'hF000; flush = 1; new_pc = 16'hFFF0; dec_pc = 16'hFFF0;
    step();
    flush = 0;
    step();
    check("r26_first_addr", 64'(bus_addr), 64'hFFFF0);
    check("r26_first_byte", 64'(bus_byte), 64'd0);
    acks = 0;
    for (int c = 0; c < 20; c++) begin
      bus_ack = m_pend; bus_data = 16'h3412;
      step();
      if (bus_ack) begin
        acks++;
        check("r26_len_rise", 64'(ipq_len), 64'(2 * acks));
        if (acks == 1) begin
          check("r26_q0", 64'(ipq[0]), 64'h12);
          check("r26_q1", 64'(ipq[1]), 64'h34);
        end
      end
    end
    bus_ack = 0;
    check("r26_full_len", 64'(ipq_len), 64'd8);
    check("r26_full_noreq", 64'(bus_req), 64'd0);

    // Full queue: consuming 1 byte is not enough, consuming 2 is
    dec_pc = dec_pc + 16'd1;
    step(); step();
    check("r30_one_free", 64'(bus_req), 64'd0);
    dec_pc = dec_pc + 16'd1;
    step();
    check("r30_two_free", 64'(bus_req), 64'd1);
    ce = 0; bus_ack = 1; bus_data = 16'hBEEF;
    step();
    check("r30_ce_low_hold", 64'(bus_req), 64'd1);
    check("r30_ce_low_len", 64'(ipq_len), 64'd6);
    ce = 1;
    step();
    bus_ack = 0;

    // Odd restart address, then the next request is even
    flush = 1; new_pc = 16'h0103; dec_pc = 16'h0103;
    step();
    flush = 0;
    step();
    check("r27_addr", 64'(bus_addr), 64'hF0103);
    check("r27_byte", 64'(bus_byte), 64'd1);
    bus_ack = 1; bus_data = 16'hAB00;
    step();
    bus_ack = 0;
    check("r27_q3", 64'(ipq[3]), 64'hAB);
    check("r27_len", 64'(ipq_len), 64'd1);
    step();
    check("r27_next_even", 64'(bus_byte), 64'd0);
    check("r27_next_addr", 64'(bus_addr), 64'hF0104);

    // Flush while the request is outstanding, late ack is discarded
    flush = 1; new_pc = 16'h0200; dec_pc = 16'h0200;
    step();
    flush = 0;
    check("r28_req_held", 64'(bus_req), 64'd1);
    check("r28_addr_held", 64'(bus_addr), 64'hF0104);
    step(); step();
    bus_ack = 1; bus_data = 16'hFFFF;
    step();
    bus_ack = 0;
    check("r28_q4_kept", 64'(ipq[4]), 64'h12);
    check("r28_len", 64'(ipq_len), 64'd0);
    step();
    check("r28_next_addr", 64'(bus_addr), 64'hF0200);

    // exec_hold raised during REQ does not stop completion, but blocks issue
    exec_hold = 1;
    step();
    bus_ack = 1; bus_data = 16'h5678;
    step();
    bus_ack = 0;
    check("r29_q0", 64'(ipq[0]), 64'h78);
    check("r29_q1", 64'(ipq[1]), 64'h56);
    step(); step(); step();
    check("r29_hold_noreq", 64'(bus_req), 64'd0);
    exec_hold = 0;

    // fetch_pc wraps from 0xFFFE, then reset during REQ ignores the late ack
    flush = 1; new_pc = 16'hFFFE; dec_pc = 16'hFFFE;
    step();
    flush = 0;
    step();
    bus_ack = 1; bus_data = 16'hCDEF;
    step();
    bus_ack = 0;
    check("r31_wrap_len", 64'(ipq_len), 64'd2);
    check("r31_q6", 64'(ipq[6]), 64'hEF);
    check("r31_q7", 64'(ipq[7]), 64'hCD);
    step();
    check("r31_reissue", 64'(bus_req), 64'd1);
    check("r31_wrap_addr", 64'(bus_addr), 64'hF0000);
    reset = 1; dec_pc = 16'h0000;
    step();
    check("r31_rst_req", 64'(bus_req), 64'd0);
    reset = 0; bus_ack = 1; bus_data = 16'h9999;
    step();
    bus_ack = 0;
    check("r31_late_ack", ipq, 64'd0);

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      reset     = ($urandom_range(0, 199) == 0);
      ce        = ($urandom_range(0, 9) != 0);
      exec_hold = ($urandom_range(0, 4) == 0);
      flush     = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 49) == 0) ps = 16'($urandom);
      new_pc    = ($urandom_range(0, 3) == 0) ? 16'hFFF8 + 16'($urandom_range(0, 7))
                                              : 16'($urandom);
      bus_ack   = m_pend ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
      bus_data  = 16'($urandom);
      if (reset) begin
        dec_pc = 16'h0000;
      end else if (flush) begin
        ce = 1;
        dec_pc = new_pc;
      end else if ($urandom_range(0, 2) == 0) begin
        len16 = m_len();
        dec_pc = dec_pc + 16'($urandom_range(0, int'(len16)));
      end
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/nec_prefetch_ctrl.md
NEC_PREFETCH_CTRL -- requirements
Module: nec_prefetch_ctrl

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: clk and reset.
REQ-002 SHALL provide ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- ce  in  1  clock enable; no state changes when low
- ps  in  16  program segment; fetch base is ps*16
- flush  in  1  discard queue and restart fetch at new_pc
- new_pc  in  16  restart offset, used with flush
- dec_pc  in  16  decoder's current pc; bytes below it are consumed
- exec_hold  in  1  execution unit owns the bus; no new prefetch request
- bus_req  out  1  prefetch bus request
- bus_addr  out  20  physical fetch address, ({ps,4'b0} + fetch_pc) mod 2^20
- bus_byte  out  1  1 = single-byte fetch from an odd address
- bus_ack  in  1  request done; bus_data valid this cycle
- bus_data  in  16  returned word: even address in [7:0], odd address in [15:8]
- ipq  out  8x8  queue storage, entry i holds the byte whose address[2:0] == i
- ipq_len  out  4  valid bytes from dec_pc, 0..8

Function
REQ-003 SHALL keep a 16-bit fetch_pc, the offset of the next byte to fetch.
REQ-004 ipq_len SHALL equal (fetch_pc - dec_pc) mod 2^16, combinationally.
REQ-005 The environment guarantees dec_pc <= fetch_pc with a difference of at most 8; behaviour is undefined otherwise.
REQ-006 ipq[fetch_pc[2:0]] SHALL be written only when a byte is accepted.
REQ-007 SHALL implement states IDLE, REQ and DISCARD.
REQ-008 IDLE->REQ when ce, !flush, !exec_hold and (8 - ipq_len) >= 2:
- latch bus_addr;
- bus_byte = fetch_pc[0];
- assert bus_req on the next cycle.
REQ-009 In REQ and DISCARD, bus_req SHALL stay high and bus_addr/bus_byte SHALL stay stable until bus_ack is sampled with ce.
REQ-010 REQ + bus_ack, even address: SHALL write bus_data[7:0] to ipq[fetch_pc[2:0]] and bus_data[15:8] to ipq[(fetch_pc+1)[2:0]], add 2 to fetch_pc, go to IDLE.
REQ-011 REQ + bus_ack, odd address: SHALL write bus_data[15:8] to ipq[fetch_pc[2:0]], add 1 to fetch_pc, go to IDLE.
REQ-012 bus_req SHALL drop in the cycle after an accepted bus_ack; a new request needs at least one IDLE cycle.
REQ-013 exec_hold SHALL only block IDLE->REQ; an issued request always completes.
REQ-014 flush in IDLE (with ce): fetch_pc <= new_pc, stay IDLE; ipq_len becomes 0 once the decoder loads dec_pc = new_pc.
REQ-015 flush in REQ (with ce): fetch_pc <= new_pc, go to DISCARD; bus_req and bus_addr unchanged.
REQ-016 DISCARD + bus_ack: SHALL write no ipq entry and leave fetch_pc unchanged, go to IDLE.
REQ-017 flush and bus_ack in the same cycle while in REQ: the returned data is discarded, fetch_pc <= new_pc, go to IDLE.
REQ-018 flush in DISCARD: fetch_pc <= new_pc, stay in DISCARD.
REQ-019 fetch_pc SHALL wrap 0xFFFF->0x0000 with no special handling.
REQ-020 bus_addr SHALL wrap modulo 2^20.
REQ-021 ps changes take effect only at the next IDLE->REQ latch.
REQ-022 ipq_len SHALL never exceed 8: a request is issued only with at least 2 free bytes, and at most 2 bytes arrive per request.

Reset
REQ-023 reset (with or without ce) SHALL set:
- state IDLE, bus_req=0, bus_byte=0, bus_addr=0;
- fetch_pc=0, all ipq entries 0x00.
REQ-024 Reset in REQ or DISCARD SHALL abandon the request; a bus_ack arriving after reset is ignored.
REQ-025 reset SHALL take priority over flush and bus_ack.

Verification
REQ-026 Reset, ps=0xF000, flush new_pc=0xFFF0, dec_pc=0xFFF0, ack every request with data 0x3412 -> first bus_addr=0xFFFF0, bus_byte=0; ipq[0]=0x12, ipq[1]=0x34; ipq_len rises 2,4,6,8; requests then stop.
REQ-027 flush new_pc=0x0103, dec_pc=0x0103 -> bus_addr=ps*16+0x103, bus_byte=1; on ack data 0xAB00, ipq[3]=0xAB, fetch_pc=0x0104; next request is even.
REQ-028 Request outstanding; flush new_pc=0x0200; ack arrives 3 cycles later -> no ipq write, ipq_len=0 with dec_pc=0x0200; next bus_addr=ps*16+0x200.
REQ-029 exec_hold=1 from IDLE with free space -> bus_req stays 0; exec_hold raised while in REQ -> request completes and data is stored.
REQ-030 Queue full (ipq_len=8); dec_pc advances by 1 -> no request; dec_pc advances by 2 -> request issued. ce=0 while bus_ack is high -> ack ignored, bus_req held.
REQ-031 fetch_pc=0xFFFE, ack -> fetch_pc=0x0000 and ipq_len=2 relative to dec_pc=0xFFFE; reset asserted while in REQ -> bus_req=0 next cycle and the late ack is ignored.
